// File: rtl/block_ram_1p.sv
// block_ram_1p: single-port word-addressed data/scratch RAM.
// The read port is registered, so data is valid one cycle after the address.
// A read during a write returns the new data (write-first).
// An out-of-range address reads as zero and never writes the array.
// Only the output register is reset; the array keeps its contents across reset.
module block_ram_1p #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] di,
    output logic [31:0] dout
);

    localparam int AW = $clog2(DEPTH);

    // The declaration initialiser gives zero contents both in simulation and
    // in the bitstream image. No reset branch ever touches the array, which
    // keeps it mappable onto a block RAM.
    logic [31:0] r_mem [DEPTH] = '{default: 32'h0000_0000};
    logic [31:0] r_dout;

    logic          w_inRange;
    logic [AW-1:0] w_index;
    logic          w_writeEn;

    // The full 32-bit address is compared, so aliases above DEPTH are rejected
    // instead of wrapping onto low words.
    assign w_inRange = (addr < 32'(DEPTH));
    assign w_index   = addr[AW-1:0];
    assign w_writeEn = we && !rst && w_inRange;

    // Array write port: there is no reset branch, and writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (w_writeEn) begin
            r_mem[w_index] <= di;
        end
    end

    // Output register: asynchronously cleared and reloaded on every edge, with write-first bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= 32'h0000_0000;
        end else if (!w_inRange) begin
            r_dout <= 32'h0000_0000;
        end else if (we) begin
            r_dout <= di;
        end else begin
            r_dout <= r_mem[w_index];
        end
    end

    assign dout = r_dout;

endmodule

// File: tb/tb_block_ram_1p.sv
// tb_block_ram_1p: scoreboard bench for block_ram_1p.
// A stimulus process drives one access per cycle. At the edge that samples it,
// the process pushes the expected dout from a plain array model of the memory.
// A monitor process pops one entry after each edge and compares it with dout.
module tb_block_ram_1p;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] di;
    logic [31:0] dout;

    typedef struct {
        string       name;
        logic [31:0] data;
    } expEntry_t;

    expEntry_t   expQ[$];
    logic [31:0] model [DEPTH];
    int          tests;
    int          failures;

    block_ram_1p #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .di   (di),
        .dout (dout)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value and count the result.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one access at the falling edge, then record what the memory must
    // return after the rising edge that samples the access.
    task automatic applyStimulus(input logic rstVal, input logic weVal, input logic [31:0] addrVal,
                                 input logic [31:0] diVal, input string name);
        expEntry_t e;
        @(negedge clk);
        rst  = rstVal;
        we   = weVal;
        addr = addrVal;
        di   = diVal;
        @(posedge clk);
        e.name = name;
        if (rstVal) begin
            e.data = 32'h0;
        end else if (addrVal >= DEPTH) begin
            e.data = 32'h0;
        end else if (weVal) begin
            e.data = diVal;
            model[addrVal] = diVal;
        end else begin
            e.data = model[addrVal];
        end
        expQ.push_back(e);
    endtask

    // Monitor: one scoreboard entry belongs to each rising edge. Check it shortly after the edge.
    initial begin
        expEntry_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e.name, dout, e.data);
            end
        end
    end

    // Watchdog so the run always ends even if the stimulus stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        int          waitCycles;
        tests    = 0;
        failures = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

        rst  = 1'b1;
        we   = 1'b0;
        addr = 32'h0;
        di   = 32'h0;
        #1;
        checkOutput("reset_initial", dout, 32'h0);

        // Reset is held for three edges with a write pending, so the write must not happen.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 32'd5, 32'd9, "reset_hold");
        applyStimulus(1'b0, 1'b0, 32'd5, 32'd0, "read5_after_reset");

        // Back-to-back writes followed by reads
        applyStimulus(1'b0, 1'b1, 32'd55,  32'd23,   "wr55");
        applyStimulus(1'b0, 1'b1, 32'd47,  32'd1,    "wr47");
        applyStimulus(1'b0, 1'b1, 32'd147, 32'd1256, "wr147");
        applyStimulus(1'b0, 1'b0, 32'd55,  32'd0, "rd55");
        applyStimulus(1'b0, 1'b0, 32'd47,  32'd0, "rd47");
        applyStimulus(1'b0, 1'b0, 32'd147, 32'd0, "rd147");
        applyStimulus(1'b0, 1'b0, 32'd55,  32'd0, "rd55_again");
        applyStimulus(1'b0, 1'b0, 32'd46,  32'd0, "rd46");
        applyStimulus(1'b0, 1'b0, 32'd147, 32'd0, "rd147_again");

        // Write-first behaviour
        applyStimulus(1'b0, 1'b1, 32'd10, 32'hDEAD_BEEF, "write_first10");
        applyStimulus(1'b0, 1'b0, 32'd10, 32'd0,         "rd10");

        // Out-of-range accesses
        applyStimulus(1'b0, 1'b1, 32'd1024, 32'd7, "oob_write1024");
        applyStimulus(1'b0, 1'b0, 32'd0,    32'd0, "rd0_after_oob");
        applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, "oob_read_max");

        // Top word boundary
        applyStimulus(1'b0, 1'b1, 32'd1023, 32'h0000_00A5, "wr1023");
        applyStimulus(1'b0, 1'b0, 32'd1023, 32'd0, "rd1023");
        applyStimulus(1'b0, 1'b0, 32'd0,    32'd0, "rd0_wrap");

        // Asynchronous reset asserted mid-stream while dout holds 1256
        applyStimulus(1'b0, 1'b0, 32'd147, 32'd0, "rd147_before_rst");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_clear", dout, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'd147, 32'd99, "write_during_rst");
        applyStimulus(1'b0, 1'b0, 32'd147, 32'd0,  "rd147_after_rst");

        // Randomized traffic, which also exercises aliases above DEPTH
        for (int i = 0; i < 400; i++) begin
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(DEPTH, DEPTH + 64));
                1:       a = 32'(DEPTH) | 32'($urandom_range(0, 31)) | (32'h1 << $urandom_range(10, 31));
                2:       a = 32'($urandom_range(0, 1)) * 32'(DEPTH - 1);
                default: a = 32'($urandom_range(0, 63));
            endcase
            applyStimulus(1'b0, w, a, d, "random");
        end

        // Drain the scoreboard within a bounded number of cycles
        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 10) begin
            @(posedge clk);
            #2;
            waitCycles++;
        end
        tests++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
